// File: rtl/leaf_pkg.sv
// Shared types and helpers for the leaf send arbiter.
// Packet field layout, FSM states and packet assembly.
package leaf_pkg;

  localparam int PKT_W  = 49;
  localparam int PAY_W  = 32;
  localparam int LEAF_W = 5;
  localparam int PORT_W = 4;
  localparam int ADDR_W = 7;

  localparam int PKT_VLD      = 48;
  localparam int PKT_LEAF_LSB = 43;
  localparam int PKT_PORT_LSB = 39;
  localparam int PKT_ADDR_LSB = 32;
  localparam int PKT_DATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_UNCONF = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  function automatic logic [PKT_W-1:0] pack_pkt(
    input logic [LEAF_W-1:0] leaf,
    input logic [PORT_W-1:0] port,
    input logic [ADDR_W-1:0] addr,
    input logic [PAY_W-1:0]  data
  );
    logic [PKT_W-1:0] p;
    p = '0;
    p[PKT_VLD]                   = 1'b1;
    p[PKT_LEAF_LSB +: LEAF_W]    = leaf;
    p[PKT_PORT_LSB +: PORT_W]    = port;
    p[PKT_ADDR_LSB +: ADDR_W]    = addr;
    p[PKT_DATA_LSB +: PAY_W]     = data;
    return p;
  endfunction

endpackage

// File: rtl/leaf_send_arbiter_rr_arbiter.sv
// Round-robin picker: first requester after last grant.
// One-hot grant, binary index and any-grant flag.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan from last+1 around the ring, first hit wins
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/leaf_send_arbiter.sv
// Credit-gated round-robin scheduler onto the BFT output channel.
// Optional per-stream stats under LEAF_SEND_ARB_STATS_EN.
module leaf_send_arbiter
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  cfg_done,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] src_data,
  input  logic [NUM_OUT_PORTS-1:0]              src_vld,
  output logic [NUM_OUT_PORTS-1:0]              src_ack,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_pkt,
  output logic                                  configured
`ifdef LEAF_SEND_ARB_STATS_EN
  ,
  output logic [NUM_OUT_PORTS*32-1:0]           stat_sent,
  output logic [NUM_OUT_PORTS*32-1:0]           stat_stall
`endif
);

  localparam int N  = NUM_OUT_PORTS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = NUM_BRAM_ADDR_BITS + 1;

  localparam logic [CW:0] CMAX =
    (CW+1)'(1 << NUM_BRAM_ADDR_BITS);
  localparam logic [CW:0] CUPD =
    (CW+1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  state_e state_q, state_d;
  logic   conf_q, conf_d;

  logic [NUM_LEAF_BITS-1:0] leaf_q [N];
  logic [NUM_LEAF_BITS-1:0] leaf_d [N];
  logic [NUM_PORT_BITS-1:0] port_q [N];
  logic [NUM_PORT_BITS-1:0] port_d [N];
  logic [NUM_ADDR_BITS-1:0] addr_q [N];
  logic [NUM_ADDR_BITS-1:0] addr_d [N];
  logic [CW-1:0]            cred_q [N];
  logic [CW-1:0]            cred_d [N];

  logic [IW-1:0]          last_q, last_d;
  logic [PACKET_BITS-1:0] pkt_q, pkt_d;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gidx;
  logic          gany;

  // control FSM: configure, run, hold on resend
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNCONF: if (cfg_done) state_d = ST_RUN;
      ST_RUN:    if (resend)   state_d = ST_HOLD;
      ST_HOLD:   if (!resend)  state_d = ST_RUN;
      default:   state_d = ST_UNCONF;
    endcase
    conf_d = (state_d != ST_UNCONF);
  end

  // a stream may bid only in RUN, with data and credit
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = (state_q == ST_RUN) && !resend
             && src_vld[i] && (cred_q[i] != '0);
    end
  end

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gidx),
    .any  (gany)
  );

  assign src_ack    = gnt;
  assign dout_pkt   = pkt_q;
  assign configured = conf_q;

  // packet build and round-robin pointer
  always_comb begin
    pkt_d  = '0;
    last_d = gany ? gidx : last_q;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        pkt_d = pack_pkt(
          leaf_q[i], port_q[i], addr_q[i],
          src_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]);
      end
    end
  end

  // per-stream dest table, addr and credit update
  always_comb begin
    logic [CW:0] nxt;
    nxt = '0;
    for (int i = 0; i < N; i++) begin
      leaf_d[i] = leaf_q[i];
      port_d[i] = port_q[i];
      if (cfg_wr && int'(cfg_port) == i) begin
        leaf_d[i] = cfg_dest_leaf;
        port_d[i] = cfg_dest_port;
      end
      addr_d[i] = addr_q[i];
      if (gnt[i]) addr_d[i] = addr_q[i] + 1'b1;
      nxt = {1'b0, cred_q[i]};
      if (gnt[i]) nxt = nxt - 1'b1;
      if (credit_vld && int'(credit_port) == i) begin
        nxt = nxt + CUPD;
      end
      if (nxt > CMAX) nxt = CMAX;
      cred_d[i] = nxt[CW-1:0];
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_UNCONF;
      conf_q  <= 1'b0;
      last_q  <= LAST_RST;
      pkt_q   <= '0;
      for (int i = 0; i < N; i++) begin
        leaf_q[i] <= '0;
        port_q[i] <= '0;
        addr_q[i] <= '0;
        cred_q[i] <= CMAX[CW-1:0];
      end
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      for (int i = 0; i < N; i++) begin
        leaf_q[i] <= leaf_d[i];
        port_q[i] <= port_d[i];
        addr_q[i] <= addr_d[i];
        cred_q[i] <= cred_d[i];
      end
    end
  end

`ifdef LEAF_SEND_ARB_STATS_EN
  logic [31:0] sent_q  [N];
  logic [31:0] sent_d  [N];
  logic [31:0] stall_q [N];
  logic [31:0] stall_d [N];

  // wrapping sent / credit-stall counters
  always_comb begin
    stat_sent  = '0;
    stat_stall = '0;
    for (int i = 0; i < N; i++) begin
      sent_d[i]  = sent_q[i] + 32'(gnt[i]);
      stall_d[i] = stall_q[i];
      if (state_q == ST_RUN && src_vld[i]
          && cred_q[i] == '0) begin
        stall_d[i] = stall_q[i] + 32'd1;
      end
      stat_sent[i*32 +: 32]  = sent_q[i];
      stat_stall[i*32 +: 32] = stall_q[i];
    end
  end

  // stats registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        sent_q[i]  <= '0;
        stall_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        sent_q[i]  <= sent_d[i];
        stall_q[i] <= stall_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_leaf_send_arbiter.sv
// Bench for leaf_send_arbiter: directed steps plus random traffic
// checked against a behavioural scheduler model.
module tb_leaf_send_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_wr;
  logic [3:0]    cfg_port;
  logic [4:0]    cfg_dest_leaf;
  logic [3:0]    cfg_dest_port;
  logic          cfg_done;
  logic [N*32-1:0] src_data;
  logic [N-1:0]  src_vld;
  logic [N-1:0]  src_ack;
  logic          credit_vld;
  logic [3:0]    credit_port;
  logic          resend;
  logic [48:0]   dout_pkt;
  logic          configured;
`ifdef LEAF_SEND_ARB_STATS_EN
  logic [N*32-1:0] stat_sent;
  logic [N*32-1:0] stat_stall;
`endif

  always #5 clk = ~clk;

  leaf_send_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_wr        (cfg_wr),
    .cfg_port      (cfg_port),
    .cfg_dest_leaf (cfg_dest_leaf),
    .cfg_dest_port (cfg_dest_port),
    .cfg_done      (cfg_done),
    .src_data      (src_data),
    .src_vld       (src_vld),
    .src_ack       (src_ack),
    .credit_vld    (credit_vld),
    .credit_port   (credit_port),
    .resend        (resend),
    .dout_pkt      (dout_pkt),
`ifdef LEAF_SEND_ARB_STATS_EN
    .stat_sent     (stat_sent),
    .stat_stall    (stat_stall),
`endif
    .configured    (configured)
  );

  int nvec  = 0;
  int nfail = 0;
  int acks  = 0;

  // model: 0 unconfigured, 1 running, 2 holding
  int          m_state;
  int          m_leaf [N];
  int          m_port [N];
  int          m_addr [N];
  int          m_cred [N];
  int          m_last;
  logic [48:0] m_pkt;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last  = N - 1;
    m_pkt   = '0;
    for (int i = 0; i < N; i++) begin
      m_leaf[i] = 0;
      m_port[i] = 0;
      m_addr[i] = 0;
      m_cred[i] = 128;
    end
  endtask

  // one clock: check at negedge, advance model at posedge
  task automatic step();
    logic [N-1:0] eack;
    int g;
    @(negedge clk);
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (g < 0 && m_state == 1 && !resend
          && src_vld[j] && m_cred[j] > 0) g = j;
    end
    eack = '0;
    if (g >= 0) eack[g] = 1'b1;
    chk("src_ack", 64'(src_ack), 64'(eack));
    chk("dout_pkt", 64'(dout_pkt), 64'(m_pkt));
    chk("configured", 64'(configured), 64'(m_state != 0));
    if (src_ack != '0) acks++;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_pkt = {1'b1, 5'(m_leaf[g]), 4'(m_port[g]),
                 7'(m_addr[g]), src_data[g*32 +: 32]};
        m_addr[g] = (m_addr[g] + 1) % 128;
        m_cred[g] = m_cred[g] - 1;
        m_last    = g;
      end else begin
        m_pkt = '0;
      end
      if (credit_vld && credit_port < N) begin
        m_cred[credit_port] = m_cred[credit_port] + 64;
        if (m_cred[credit_port] > 128) m_cred[credit_port] = 128;
      end
      if (cfg_wr && cfg_port < N) begin
        m_leaf[cfg_port] = cfg_dest_leaf;
        m_port[cfg_port] = cfg_dest_port;
      end
      case (m_state)
        0: if (cfg_done) m_state = 1;
        1: if (resend) m_state = 2;
        default: if (!resend) m_state = 1;
      endcase
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_cfg();
    src_vld = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_wr = 1'b1;
    cfg_port = 4'd0; cfg_dest_leaf = 5'd3; cfg_dest_port = 4'd1;
    step();
    cfg_port = 4'd1; cfg_dest_leaf = 5'd7; cfg_dest_port = 4'd2;
    step();
    cfg_wr = 1'b0;
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
  endtask

  initial begin
    logic [48:0] first;
    first = {1'b1, 5'd3, 4'd1, 7'd0, 32'hA5A5_0001};
    model_reset();
    reset = 1'b1; cfg_wr = 1'b0; cfg_port = '0;
    cfg_dest_leaf = '0; cfg_dest_port = '0; cfg_done = 1'b0;
    src_data = '0; src_vld = '0; credit_vld = 1'b0;
    credit_port = '0; resend = 1'b0;
    steps(2);

    // config then single stream on 0
    reset_cfg();
    src_vld = 2'b01;
    src_data = {32'h0, 32'hA5A5_0001};
    step();
    chk("first_pkt", 64'(dout_pkt), 64'(first));
    src_vld = '0;
    step();

    // round robin, both streams busy
    acks = 0;
    src_vld = 2'b11;
    for (int i = 0; i < 8; i++) begin
      src_data = {$urandom, $urandom};
      step();
    end
    chk("rr_acks", 64'(acks), 64'd8);
    src_vld = '0;

    // credit exhaustion then one refill
    reset_cfg();
    acks = 0;
    src_vld = 2'b01;
    for (int i = 0; i < 130; i++) begin
      src_data = {$urandom, $urandom};
      step();
    end
    chk("exhaust_acks", 64'(acks), 64'd128);
    credit_vld = 1'b1; credit_port = 4'd0;
    acks = 0;
    step();
    credit_vld = 1'b0;
    steps(70);
    chk("refill_acks", 64'(acks), 64'd64);
    src_vld = '0;

    // grant and update together at full credit
    reset_cfg();
    acks = 0;
    src_vld = 2'b01;
    credit_vld = 1'b1; credit_port = 4'd0;
    step();
    credit_vld = 1'b0;
    steps(135);
    chk("sat_acks", 64'(acks), 64'd129);
    src_vld = '0;

    // resend hold mid-stream
    reset_cfg();
    src_vld = 2'b01;
    steps(3);
    resend = 1'b1;
    acks = 0;
    steps(5);
    chk("hold_acks", 64'(acks), 64'd0);
    resend = 1'b0;
    steps(5);

    // reset mid-operation, no grants until cfg_done
    src_vld = 2'b11;
    reset = 1'b1;
    step();
    reset = 1'b0;
    acks = 0;
    steps(4);
    chk("post_reset_acks", 64'(acks), 64'd0);
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    steps(4);

    // cfg_done while resend is high
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_done = 1'b1; resend = 1'b1;
    step();
    cfg_done = 1'b0;
    steps(2);
    resend = 1'b0;
    steps(3);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      src_vld       = N'($urandom);
      src_data      = {$urandom, $urandom};
      credit_vld    = ($urandom_range(0, 39) == 0);
      credit_port   = 4'($urandom_range(0, 3));
      resend        = ($urandom_range(0, 9) == 0);
      cfg_wr        = ($urandom_range(0, 19) == 0);
      cfg_port      = 4'($urandom);
      cfg_dest_leaf = 5'($urandom);
      cfg_dest_port = 4'($urandom);
      cfg_done      = ($urandom_range(0, 29) == 0);
      reset         = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
